// File: rtl/csr_dump_unit_if.sv
// Handshake and CSR read-port bundle for the counter dump unit.
// The master side drives requests, read data and back-pressure.
interface csr_dump_unit_if #(
  parameter int DATA_W = 64
) ();
  logic              start;
  logic              abort;
  logic [11:0]       csrAddr;
  logic              csrRead;
  logic [DATA_W-1:0] csrData;
  logic              outValid;
  logic              outReady;
  logic [DATA_W-1:0] outData;
  logic [2:0]        outIndex;
  logic              outLast;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, csrData, outReady,
    input  csrAddr, csrRead, outValid,
    input  outData, outIndex, outLast,
    input  busy, done
  );

  modport slave (
    input  start, abort, csrData, outReady,
    output csrAddr, csrRead, outValid,
    output outData, outIndex, outLast,
    output busy, done
  );
endinterface

// File: rtl/csr_dump_unit.sv
// Snapshots six performance counters into a buffer, then streams
// them out as indexed beats under valid/ready flow control.
module csr_dump_unit #(
  parameter int DATA_W  = 64,
  parameter int NUM_CSR = 6
) (
  input logic          clk,
  input logic          reset,
  csr_dump_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SEND,
    DONE
  } state_t;

  localparam logic [2:0] LAST = 3'(NUM_CSR - 1);

  state_t            state_q, state_d;
  logic [2:0]        slot_q, slot_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [DATA_W-1:0] buf_q [NUM_CSR];
  logic [DATA_W-1:0] buf_d [NUM_CSR];

  function automatic logic [11:0] csr_addr(
    input logic [2:0] s
  );
    unique case (s)
      3'd0:    return 12'hB00;
      3'd1:    return 12'hB02;
      3'd2:    return 12'hB03;
      3'd3:    return 12'hB04;
      3'd4:    return 12'hB05;
      3'd5:    return 12'hB06;
      default: return 12'h000;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    ptr_d        = ptr_q;
    buf_d        = buf_q;
    bus.csrRead  = 1'b0;
    bus.csrAddr  = '0;
    bus.outValid = 1'b0;
    bus.outData  = '0;
    bus.outIndex = '0;
    bus.outLast  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = CAPTURE;
          slot_d  = '0;
        end
      end
      CAPTURE: begin
        bus.csrRead = 1'b1;
        bus.csrAddr = csr_addr(slot_q);
        if (bus.abort) begin
          state_d = IDLE;
          slot_d  = '0;
        end else begin
          buf_d[slot_q] = bus.csrData;
          if (slot_q == LAST) begin
            state_d = SEND;
            slot_d  = '0;
            ptr_d   = '0;
          end else begin
            slot_d = slot_q + 3'd1;
          end
        end
      end
      SEND: begin
        bus.outValid = 1'b1;
        bus.outData  = buf_q[ptr_q];
        bus.outIndex = ptr_q;
        bus.outLast  = (ptr_q == LAST);
        // abort outranks acceptance of the offered beat
        if (bus.abort) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else if (bus.outReady) begin
          if (ptr_q == LAST) begin
            state_d = DONE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + 3'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < NUM_CSR; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      ptr_q   <= ptr_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_csr_dump_unit.sv
// Randomized bench for csr_dump_unit with a queue-based
// reference model checked against the DUT every cycle.
module tb_csr_dump_unit;
  localparam logic [63:0] BASE = 64'h1000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  bit          mode = 1'b0;
  logic [63:0] cyc = '0;
  int          checks = 0;
  int          errors = 0;

  csr_dump_unit_if #(.DATA_W(64)) bus ();

  csr_dump_unit #(
    .DATA_W(64),
    .NUM_CSR(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 64'd1;

  assign bus.csrData = mode ? cyc : (BASE + {52'd0, bus.csrAddr});

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic [11:0] tbl [6] = '{12'hB00, 12'hB02, 12'hB03,
                           12'hB04, 12'hB05, 12'hB06};

  // reference model: a capture count, then a queue of pending beats
  bit          m_cap;
  int          m_n;
  logic [63:0] m_buf [6];
  logic [63:0] m_q [$];
  bit          m_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cap  = 1'b0;
      m_n    = 0;
      m_done = 1'b0;
      m_q.delete();
    end else if (m_cap) begin
      if (bus.abort) m_cap = 1'b0;
      else begin
        m_buf[m_n] = mode ? cyc : BASE + {52'd0, tbl[m_n]};
        m_n++;
        if (m_n == 6) begin
          m_cap = 1'b0;
          for (int k = 0; k < 6; k++) m_q.push_back(m_buf[k]);
        end
      end
    end else if (m_q.size() > 0) begin
      if (bus.abort) m_q.delete();
      else if (bus.outReady) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (bus.start && !bus.abort) begin
      m_cap = 1'b1;
      m_n   = 0;
    end
  end

  logic [63:0] addr_log [$];
  logic [63:0] beat_log [$];
  bit          last_log [$];
  int          done_cnt = 0;
  bit          stall_q = 1'b0;
  logic [63:0] pv_data;
  logic [2:0]  pv_idx;
  logic        pv_last;

  always @(posedge clk) begin
    stall_q = 1'b0;
    if (!reset) begin
      if (bus.csrRead) addr_log.push_back({52'd0, bus.csrAddr});
      if (bus.outValid && bus.outReady && !bus.abort) begin
        beat_log.push_back(bus.outData);
        last_log.push_back(bus.outLast);
      end
      if (bus.done) done_cnt++;
      stall_q = bus.outValid && !bus.outReady && !bus.abort;
      pv_data = bus.outData;
      pv_idx  = bus.outIndex;
      pv_last = bus.outLast;
    end
  end

  always @(negedge clk) begin
    bit snd;
    int idx;
    snd = !m_cap && (m_q.size() > 0);
    idx = 6 - m_q.size();
    chk("csrRead", {63'd0, bus.csrRead}, {63'd0, m_cap});
    chk("csrAddr", {52'd0, bus.csrAddr},
        m_cap ? {52'd0, tbl[m_n]} : 64'd0);
    chk("outValid", {63'd0, bus.outValid}, {63'd0, snd});
    chk("outData", bus.outData, snd ? m_q[0] : 64'd0);
    chk("outIndex", {61'd0, bus.outIndex}, snd ? 64'(idx) : 64'd0);
    chk("outLast", {63'd0, bus.outLast}, {63'd0, snd && idx == 5});
    chk("busy", {63'd0, bus.busy},
        {63'd0, m_cap || m_q.size() > 0 || m_done});
    chk("done", {63'd0, bus.done}, {63'd0, m_done});
    if (stall_q && !reset) begin
      chk("stall_valid", {63'd0, bus.outValid}, 64'd1);
      chk("stall_data", bus.outData, pv_data);
      chk("stall_idx", {61'd0, bus.outIndex}, {61'd0, pv_idx});
      chk("stall_last", {63'd0, bus.outLast}, {63'd0, pv_last});
    end
  end

  task automatic clear_logs();
    addr_log.delete();
    beat_log.delete();
    last_log.delete();
    done_cnt = 0;
  endtask

  task automatic run_dump(input bit rnd, input int ea,
                          input int eb, output int lat);
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    lat = 1;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (rnd) bus.outReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
        bus.start = (lat == ea) || (lat == eb);
      end
    end
    bus.start = 1'b0;
    bus.outReady = 1'b1;
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_const_dump(input string nm);
    chk({nm, "_naddr"}, 64'(addr_log.size()), 64'd6);
    chk({nm, "_nbeat"}, 64'(beat_log.size()), 64'd6);
    for (int k = 0; k < 6; k++) begin
      chk({nm, "_addr"}, addr_log[k],
          k == 0 ? 64'hB00 : 64'hB01 + 64'(k));
      chk({nm, "_beat"}, beat_log[k],
          k == 0 ? 64'h1000_0000_0000_0B00
                 : 64'h1000_0000_0000_0B01 + 64'(k));
      chk({nm, "_last"}, {63'd0, last_log[k]}, {63'd0, k == 5});
    end
    chk({nm, "_dones"}, 64'(done_cnt), 64'd1);
  endtask

  initial begin
    int lat;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.outReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_valid", {63'd0, bus.outValid}, 64'd0);
    chk("rst_read", {63'd0, bus.csrRead}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    clear_logs();
    run_dump(1'b0, -1, -1, lat);
    chk("latency", 64'(lat), 64'd13);
    check_const_dump("basic");

    mode = 1'b1;
    for (int r = 0; r < 5; r++) begin
      clear_logs();
      run_dump(1'b1, -1, -1, lat);
      chk("rnd_nbeat", 64'(beat_log.size()), 64'd6);
      for (int k = 0; k < 6; k++) begin
        chk("rnd_beat", beat_log[k], beat_log[0] + 64'(k));
        chk("rnd_last", {63'd0, last_log[k]}, {63'd0, k == 5});
      end
      chk("rnd_dones", 64'(done_cnt), 64'd1);
    end

    mode = 1'b0;
    clear_logs();
    run_dump(1'b0, 3, 9, lat);
    repeat (20) @(posedge clk);
    #1;
    check_const_dump("restart");

    clear_logs();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.outValid && bus.outIndex == 3'd2) break;
      @(posedge clk); #1;
    end
    chk("abort_at2", {61'd0, bus.outIndex}, 64'd2);
    bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    chk("abort_valid", {63'd0, bus.outValid}, 64'd0);
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_nbeat", 64'(beat_log.size()), 64'd2);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_dones", 64'(done_cnt), 64'd0);
    clear_logs();
    run_dump(1'b0, -1, -1, lat);
    check_const_dump("post_abort");

    clear_logs();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("ar_busy", {63'd0, bus.busy}, 64'd0);
    chk("ar_read", {63'd0, bus.csrRead}, 64'd0);
    chk("ar_addr", {52'd0, bus.csrAddr}, 64'd0);
    chk("ar_valid", {63'd0, bus.outValid}, 64'd0);
    chk("ar_data", bus.outData, 64'd0);
    chk("ar_idx", {61'd0, bus.outIndex}, 64'd0);
    chk("ar_last", {63'd0, bus.outLast}, 64'd0);
    chk("ar_done", {63'd0, bus.done}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("ar_dones", 64'(done_cnt), 64'd0);

    clear_logs();
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("sa_busy", {63'd0, bus.busy}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("sa_busy2", {63'd0, bus.busy}, 64'd0);
    chk("sa_reads", 64'(addr_log.size()), 64'd0);

    clear_logs();
    run_dump(1'b0, -1, -1, lat);
    chk("final_latency", 64'(lat), 64'd13);
    check_const_dump("final");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
